// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key count, code width, code type, and
// small combinational helpers for the key-vector encoder.
package keypad_pkg;

  localparam int unsigned NUM_KEYS     = 12;
  localparam int unsigned KEY_CODE_W   = 4;
  localparam int unsigned PRESS_CNT_W  = 8;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Internal "no key pressed" marker; never appears on key_code.
  localparam key_code_t NO_KEY = 4'hF;

  // Lowest set index of the debounced vector, or NO_KEY when empty.
  function automatic key_code_t lowest_key(input logic [NUM_KEYS-1:0] v);
    key_code_t r;
    r = NO_KEY;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (v[i]) r = KEY_CODE_W'(i);
    end
    return r;
  endfunction

  // True when two or more bits are set (clearing the lowest set bit
  // leaves something behind).
  function automatic logic two_or_more(input logic [NUM_KEYS-1:0] v);
    return (v & (v - NUM_KEYS'(1))) != '0;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single key line conditioner: 2-flop synchronizer followed by a
// tick-sampled debouncer that flips its output only after DEB_TICKS
// consecutive samples disagree with it.
// Ports:
//   clk_raw - system clock
//   rst     - asynchronous active-high reset
//   tick    - sample strobe (one clk_raw cycle wide)
//   raw     - asynchronous raw key line, 1 = pressed
//   deb     - debounced key level
module key_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic clk_raw,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic deb
);

  localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronizer and disagreement counter.
  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        if (sync2 != deb) begin
          if (cnt == CNT_W'(DEB_TICKS - 1)) begin
            deb <= ~deb;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/keystroke_core.sv
// Keypad front-end: debounces the 12 raw key lines, reports the lowest
// pressed key as a press pulse with auto-repeat, and counts presses.
// Ports:
//   clk_raw     - system clock (only clock)
//   rst         - asynchronous active-high reset
//   keystroke   - raw key lines, 1 = pressed, asynchronous
//   key_code    - index of lowest debounced pressed key (holds when idle)
//   key_press   - one-cycle pulse on new press or auto-repeat
//   key_held    - at least one debounced key pressed
//   multi_key   - two or more debounced keys pressed
//   press_count - number of key_press pulses, wrapping
module keystroke_core
  import keypad_pkg::*;
#(
  parameter int unsigned DIV_W        = 10,
  parameter int unsigned DEB_TICKS    = 4,
  parameter int unsigned REPEAT_TICKS = 32
) (
  input  logic                   clk_raw,
  input  logic                   rst,
  input  logic [NUM_KEYS-1:0]    keystroke,
  output key_code_t              key_code,
  output logic                   key_press,
  output logic                   key_held,
  output logic                   multi_key,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);

  logic [DIV_W-1:0]    div;
  logic                tick_c;
  logic [NUM_KEYS-1:0] deb_vec;
  key_code_t           enc_c;
  key_code_t           prev_idx;
  logic                held_c;
  logic                multi_c;
  logic                new_evt_c;
  logic                rep_evt_c;
  logic                press_c;
  logic [REP_W-1:0]    rep_cnt;
  logic [REP_W-1:0]    rep_cnt_nxt;

  assign tick_c = &div;

  // One conditioner per key line.
  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
    key_debounce #(
      .DEB_TICKS(DEB_TICKS)
    ) u_deb (
      .clk_raw(clk_raw),
      .rst    (rst),
      .tick   (tick_c),
      .raw    (keystroke[g]),
      .deb    (deb_vec[g])
    );
  end

  // Encoder, event detection and repeat counter next state.
  always_comb begin
    enc_c       = lowest_key(deb_vec);
    held_c      = |deb_vec;
    multi_c     = two_or_more(deb_vec);
    new_evt_c   = held_c && (enc_c != prev_idx);
    rep_evt_c   = 1'b0;
    rep_cnt_nxt = rep_cnt;
    // A new index restarts the repeat interval; that also absorbs a
    // repeat falling in the same cycle so only one pulse is emitted.
    if (new_evt_c || !held_c) begin
      rep_cnt_nxt = '0;
    end else if (tick_c) begin
      if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
        rep_evt_c   = 1'b1;
        rep_cnt_nxt = '0;
      end else begin
        rep_cnt_nxt = rep_cnt + REP_W'(1);
      end
    end
    press_c = new_evt_c | rep_evt_c;
  end

  // Divider, tracking state and registered outputs.
  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) begin
      div         <= '0;
      prev_idx    <= NO_KEY;
      rep_cnt     <= '0;
      key_code    <= '0;
      key_press   <= 1'b0;
      key_held    <= 1'b0;
      multi_key   <= 1'b0;
      press_count <= '0;
    end else begin
      div       <= div + DIV_W'(1);
      prev_idx  <= enc_c;
      rep_cnt   <= rep_cnt_nxt;
      key_press <= press_c;
      key_held  <= held_c;
      multi_key <= multi_c;
      if (new_evt_c) key_code <= enc_c;
      if (press_c)   press_count <= press_count + PRESS_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_keystroke_core.sv
// Bench for keystroke_core with a fast divider; a behavioural model of
// the keypad rules runs beside the DUT.
module tb_keystroke_core;

  localparam int unsigned DIV_W = 4;
  localparam int unsigned DEB   = 4;
  localparam int unsigned REP   = 8;
  localparam int          TICKP = 1 << DIV_W;

  logic        clk_raw = 1'b0;
  logic        rst;
  logic [11:0] keystroke;
  logic [3:0]  key_code;
  logic        key_press;
  logic        key_held;
  logic        multi_key;
  logic [7:0]  press_count;

  always #5 clk_raw = ~clk_raw;

  keystroke_core #(
    .DIV_W(DIV_W), .DEB_TICKS(DEB), .REPEAT_TICKS(REP)
  ) dut (
    .clk_raw(clk_raw), .rst(rst), .keystroke(keystroke),
    .key_code(key_code), .key_press(key_press), .key_held(key_held),
    .multi_key(multi_key), .press_count(press_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int          m_cyc;
  logic [11:0] m_h1, m_h2, m_deb;
  int          m_run [12];
  int          m_prev;
  int          m_rcnt;
  logic [3:0]  m_code;
  logic        m_press, m_held, m_multi;
  logic [7:0]  m_count;

  function automatic int lowest(input logic [11:0] v);
    int r = -1;
    for (int i = 11; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_h1 = '0; m_h2 = '0; m_deb = '0; m_prev = -1; m_rcnt = 0;
    for (int i = 0; i < 12; i++) m_run[i] = 0;
    m_code = '0; m_press = 0; m_held = 0; m_multi = 0; m_count = '0;
  endtask

  task automatic model_step();
    bit tick, nw, rep;
    int lo;
    tick = (m_cyc % TICKP) == TICKP - 1;
    lo   = lowest(m_deb);
    nw   = (lo >= 0) && (lo != m_prev);
    rep  = 0;
    if (nw || lo < 0) m_rcnt = 0;
    else if (tick) begin
      m_rcnt++;
      if (m_rcnt == int'(REP)) begin rep = 1; m_rcnt = 0; end
    end
    m_press = nw || rep;
    if (nw) m_code = 4'(lo);
    if (m_press) m_count = m_count + 8'd1;
    m_held  = (m_deb != 0);
    m_multi = ($countones(m_deb) >= 2);
    m_prev  = lo;
    // a key level is accepted after DEB consecutive disagreeing samples
    if (tick) for (int i = 0; i < 12; i++) begin
      if (m_h2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEB)) begin m_deb[i] = ~m_deb[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    m_h2 = m_h1; m_h1 = keystroke; m_cyc++;
  endtask

  always @(posedge clk_raw or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  wire [14:0] act_vec = {key_code, key_press, key_held, multi_key, press_count};
  wire [14:0] exp_vec = {m_code, m_press, m_held, m_multi, m_count};

  // ---------------- stimulus helpers (no checking) ----------------
  int pulses, exp_pulses;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_raw);
      if (key_press) pulses++;
      if (m_press)   exp_pulses++;
    end
  endtask

  task automatic wait_press(input int limit, input logic [3:0] code, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk_raw);
      if (key_press && key_code == code) ok = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; keystroke = '0;
    run(3);
    if (act_vec !== 15'd0) begin n_bad++; $display("FAIL reset_out got=%h want=0", act_vec); end
    n_cmp++;
    rst = 1'b0; pulses = 0; exp_pulses = 0;
    run(200);
    if (pulses !== 0) begin n_bad++; $display("FAIL idle_pulses got=%0d want=0", pulses); end
    n_cmp++;
    if (act_vec !== 15'd0) begin n_bad++; $display("FAIL idle_out got=%h want=0", act_vec); end
    n_cmp++;
  endtask

  task automatic test_two_keys();
    keystroke = 12'h042; pulses = 0; exp_pulses = 0;
    run(100);
    if (pulses !== 1) begin n_bad++; $display("FAIL two_keys_pulses got=%0d want=1", pulses); end
    n_cmp++;
    if ({key_code, key_held, multi_key, press_count} !== {4'd1, 1'b1, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL two_keys_state got=%h/%b/%b/%0d want=1/1/1/1",
                        key_code, key_held, multi_key, press_count);
    end
    n_cmp++;
    if (act_vec !== exp_vec) begin n_bad++; $display("FAIL two_keys_model got=%h want=%h", act_vec, exp_vec); end
    n_cmp++;
  endtask

  task automatic test_same_lowest();
    keystroke = 12'h022; pulses = 0; exp_pulses = 0;
    run(70);
    if (pulses !== 0) begin n_bad++; $display("FAIL same_low_pulses got=%0d want=0", pulses); end
    n_cmp++;
    if ({key_code, multi_key} !== {4'd1, 1'b1}) begin
      n_bad++; $display("FAIL same_low_state got=%h/%b want=1/1", key_code, multi_key);
    end
    n_cmp++;
    keystroke = 12'h222; pulses = 0; exp_pulses = 0;
    run(70);
    if (key_code !== 4'd1) begin n_bad++; $display("FAIL bit9_code got=%h want=1", key_code); end
    n_cmp++;
    if (pulses !== exp_pulses) begin n_bad++; $display("FAIL bit9_pulses got=%0d want=%0d", pulses, exp_pulses); end
    n_cmp++;
    if (act_vec !== exp_vec) begin n_bad++; $display("FAIL bit9_model got=%h want=%h", act_vec, exp_vec); end
    n_cmp++;
  endtask

  task automatic test_new_index_repeat();
    bit ok;
    logic [7:0] cnt0;
    keystroke = 12'h088;
    wait_press(150, 4'd3, ok);
    if (!ok) begin n_bad++; $display("FAIL new_index_timeout got=none want=press code 3"); end
    n_cmp++;
    cnt0 = press_count; pulses = 0; exp_pulses = 0;
    run(130);
    if (pulses !== 1) begin n_bad++; $display("FAIL repeat1_pulses got=%0d want=1", pulses); end
    n_cmp++;
    if (press_count !== cnt0 + 8'd1) begin
      n_bad++; $display("FAIL repeat1_count got=%0d want=%0d", press_count, cnt0 + 8'd1);
    end
    n_cmp++;
    run(128);
    if (pulses !== 2) begin n_bad++; $display("FAIL repeat2_pulses got=%0d want=2", pulses); end
    n_cmp++;
    if ({key_code, press_count} !== {4'd3, cnt0 + 8'd2}) begin
      n_bad++; $display("FAIL repeat2_state got=%h/%0d want=3/%0d", key_code, press_count, cnt0 + 8'd2);
    end
    n_cmp++;
    if (act_vec !== exp_vec) begin n_bad++; $display("FAIL repeat_model got=%h want=%h", act_vec, exp_vec); end
    n_cmp++;
  endtask

  task automatic test_glitch();
    keystroke = 12'h089; pulses = 0; exp_pulses = 0;
    run(2 * TICKP);
    keystroke = 12'h088;
    run(80);
    if (key_code !== 4'd3) begin n_bad++; $display("FAIL glitch_code got=%h want=3", key_code); end
    n_cmp++;
    if (pulses !== exp_pulses) begin n_bad++; $display("FAIL glitch_pulses got=%0d want=%0d", pulses, exp_pulses); end
    n_cmp++;
    if (act_vec !== exp_vec) begin n_bad++; $display("FAIL glitch_model got=%h want=%h", act_vec, exp_vec); end
    n_cmp++;
  endtask

  task automatic test_reset_mid_hold();
    bit ok;
    @(negedge clk_raw);
    rst = 1'b1;
    #1;
    if (act_vec !== 15'd0) begin n_bad++; $display("FAIL async_reset got=%h want=0", act_vec); end
    n_cmp++;
    @(negedge clk_raw);
    rst = 1'b0;
    wait_press(100, 4'd3, ok);
    if (!ok) begin n_bad++; $display("FAIL rehold_timeout got=none want=press code 3"); end
    n_cmp++;
    if ({key_code, key_held, press_count} !== {4'd3, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL rehold_state got=%h/%b/%0d want=3/1/1", key_code, key_held, press_count);
    end
    n_cmp++;
    @(negedge clk_raw);
    if (act_vec !== exp_vec) begin n_bad++; $display("FAIL rehold_model got=%h want=%h", act_vec, exp_vec); end
    n_cmp++;
  endtask

  task automatic test_random();
    int hold;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       keystroke = '0;
        1:       keystroke = 12'(1 << $urandom_range(0, 11));
        default: keystroke = 12'($urandom);
      endcase
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 40) : $urandom_range(60, 200);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk_raw);
        if (act_vec !== exp_vec) begin
          n_bad++;
          $display("FAIL random_it%0d got=%h want=%h keys=%h", it, act_vec, exp_vec, keystroke);
        end
        n_cmp++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; keystroke = '0;
    test_reset();
    test_two_keys();
    test_same_lowest();
    test_new_index_repeat();
    test_glitch();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
